// File: rtl/cmp_arbiter_pkg.sv
// Shared definitions for the compare arbiter: op-code constants and the
// result-select helper used by every comparator built on cmp_unit.
package cmp_arbiter_pkg;

    localparam int CMP_OP_W = 3;

    localparam logic [CMP_OP_W-1:0] CMP_OP_LT = 3'd0;
    localparam logic [CMP_OP_W-1:0] CMP_OP_LE = 3'd1;
    localparam logic [CMP_OP_W-1:0] CMP_OP_GT = 3'd2;
    localparam logic [CMP_OP_W-1:0] CMP_OP_GE = 3'd3;
    localparam logic [CMP_OP_W-1:0] CMP_OP_EQ = 3'd4;
    localparam logic [CMP_OP_W-1:0] CMP_OP_NE = 3'd5;

    // Derives every relation from one less-than and one equality; reserved codes give 0.
    function automatic logic cmp_select(
        input logic                lt,
        input logic                eq,
        input logic [CMP_OP_W-1:0] op
    );
        logic q;
        case (op)
            CMP_OP_LT: q = lt;
            CMP_OP_LE: q = lt | eq;
            CMP_OP_GT: q = ~(lt | eq);
            CMP_OP_GE: q = ~lt;
            CMP_OP_EQ: q = eq;
            CMP_OP_NE: q = ~eq;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/cmp_unit.sv
// Purely combinational W-bit comparator: signed/unsigned relational ops plus EQ/NE.
module cmp_unit
    import cmp_arbiter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]        a_i,
    input  logic [W-1:0]        b_i,
    input  logic [CMP_OP_W-1:0] op_i,
    input  logic                is_signed_i,
    output logic                q_o
);

    logic lt_s;
    logic eq_s;

    // Signed less-than reuses the unsigned comparator by flipping both sign bits.
    always_comb begin
        eq_s = (a_i == b_i);
        if (is_signed_i) begin
            lt_s = ({~a_i[W-1], a_i[W-2:0]} < {~b_i[W-1], b_i[W-2:0]});
        end else begin
            lt_s = (a_i < b_i);
        end
        q_o = cmp_select(lt_s, eq_s, op_i);
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one registered cmp_unit among N requesters.
// Optional saturating per-requester grant counters: define CMP_ARB_STATS_EN.
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 32,
    parameter  int CNT_W = 16,
    localparam int IW    = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req_i,
    input  logic [CMP_OP_W*N-1:0] op_i,
    input  logic [N-1:0]          signed_i,
    input  logic [W*N-1:0]        a_i,
    input  logic [W*N-1:0]        b_i,
    output logic [N-1:0]          gnt_o,
    output logic                  rsp_valid_o,
    output logic [IW-1:0]         rsp_id_o,
    output logic                  rsp_q_o,
    input  logic                  rsp_ready_i
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [CNT_W*N-1:0]    grant_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    if (N < 2) begin : g_bad_n
        $error("cmp_arbiter: N must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("cmp_arbiter: CNT_W must be at least 1");
    end
    if (W < 2) begin : g_bad_w
        $error("cmp_arbiter: W must be at least 2");
    end

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       ptr_d;
    logic [IW-1:0]       rsp_id_q;
    logic                rsp_q_q;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic [CMP_OP_W-1:0] op_q;
    logic                sgn_q;

    logic [IW:0]         idx_s;
    logic [IW-1:0]       win_s;
    logic                found_s;
    logic                take_s;
    logic [N-1:0]        gnt_s;
    logic [W-1:0]        a_sel_s;
    logic [W-1:0]        b_sel_s;
    logic [CMP_OP_W-1:0] op_sel_s;
    logic                sgn_sel_s;
    logic                cmp_q_s;

    // Round-robin search: first set request at or above ptr, wrapping past N-1.
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 0; i < N; i++) begin
            idx_s = {1'b0, ptr_q} + (IW+1)'(i);
            if (idx_s >= (IW+1)'(N)) begin
                idx_s = idx_s - (IW+1)'(N);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_i[idx_s[IW-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[IW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    assign take_s = (state_q == ST_IDLE) && found_s;

    // Grant pulse is combinational so the requester sees it in its capture cycle.
    always_comb begin
        gnt_s = '0;
        if (take_s && !rst) begin
            gnt_s[win_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    // Operand mux selecting the winning requester's lane.
    always_comb begin
        a_sel_s   = '0;
        b_sel_s   = '0;
        op_sel_s  = '0;
        sgn_sel_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (win_s == IW'(k)) begin
                a_sel_s   = a_i[k*W +: W];
                b_sel_s   = b_i[k*W +: W];
                op_sel_s  = op_i[k*CMP_OP_W +: CMP_OP_W];
                sgn_sel_s = signed_i[k];
            end else begin
                a_sel_s   = a_sel_s;
            end
        end
    end

    cmp_unit #(
        .W (W)
    ) u_cmp (
        .a_i         (a_q),
        .b_i         (b_q),
        .op_i        (op_q),
        .is_signed_i (sgn_q),
        .q_o         (cmp_q_s)
    );

    // FSM next state; ptr advances past the winner only on the response handshake.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                    if (rsp_id_q == IW'(N-1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = rsp_id_q + IW'(1);
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, operand latches and response register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            rsp_id_q <= '0;
            rsp_q_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            sgn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (take_s) begin
                a_q      <= a_sel_s;
                b_q      <= b_sel_s;
                op_q     <= op_sel_s;
                sgn_q    <= sgn_sel_s;
                rsp_id_q <= win_s;
            end
            if (state_q == ST_CALC) begin
                rsp_q_q <= cmp_q_s;
            end
        end
    end

    assign gnt_o       = gnt_s;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_q_o     = rsp_q_q;

`ifdef CMP_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N];

    // Per-requester grant counters, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (gnt_s[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        grant_cnt_o = '0;
        for (int k = 0; k < N; k++) begin
            grant_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end
`endif

endmodule
